// File: rtl/timer_text_writer.sv
// timer_text_writer: owns the write port of the character RAM. After reset it
// fills every screen cell with a space, then keeps an MM:SS elapsed-time counter
// and rewrites its five ASCII characters whenever the value changes.
module timer_text_writer #(
  parameter int unsigned TICK_DIV     = 25_000_000,
  parameter int unsigned SCREEN_CELLS = 4800,
  parameter int unsigned TEXT_ROW     = 0,
  parameter int unsigned TEXT_COL     = 36
) (
  input  logic        clock25MHz,
  input  logic        reset,
  input  logic        run,
  input  logic        timerClear,
  output logic [12:0] charRamAddrA,
  output logic [6:0]  charRamDataA,
  output logic        charRamWeA,
  output logic        busy,
  output logic [15:0] timeBcd
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [12:0]   ROW13     = 13'(TEXT_ROW);
  localparam logic [12:0]   BASE      = (ROW13 << 6) + (ROW13 << 4) + 13'(TEXT_COL);
  localparam logic [12:0]   CLR_LAST  = 13'(SCREEN_CELLS - 1);
  localparam logic [6:0]    ASCII_SP  = 7'h20;
  localparam logic [6:0]    ASCII_0   = 7'h30;
  localparam logic [6:0]    ASCII_COL = 7'h3A;

  typedef enum logic [1:0] {S_CLEAR, S_WRITE, S_IDLE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [12:0] clr_cnt_q, clr_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0] time_q, time_d;
  logic [15:0] snap_q, snap_d;
  logic        pending_q, pending_d;
  logic [12:0] addr_q, addr_d;
  logic [6:0]  data_q, data_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;

  logic        tick;
  logic        set_pend;
  logic        wr_first;
  logic [3:0]  s1, s10, m1, m10;

  // State and all registered outputs
  always_ff @(posedge clock25MHz or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      idx_q     <= '0;
      clr_cnt_q <= '0;
      presc_q   <= '0;
      time_q    <= '0;
      snap_q    <= '0;
      pending_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= ASCII_SP;
      we_q      <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      clr_cnt_q <= clr_cnt_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
    end
  end

  // Prescaler, saturating BCD time counter and pending-request source
  always_comb begin
    tick     = run && (presc_q == PRESC_MAX);
    presc_d  = presc_q;
    time_d   = time_q;
    set_pend = 1'b0;
    s1  = time_q[3:0];
    s10 = time_q[7:4];
    m1  = time_q[11:8];
    m10 = time_q[15:12];
    if (s1 != 4'd9) begin
      s1 = s1 + 4'd1;
    end else begin
      s1 = 4'd0;
      if (s10 != 4'd5) begin
        s10 = s10 + 4'd1;
      end else begin
        s10 = 4'd0;
        if (m1 != 4'd9) begin
          m1 = m1 + 4'd1;
        end else begin
          m1  = 4'd0;
          m10 = m10 + 4'd1;
        end
      end
    end
    if (timerClear) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (timerClear) begin
      time_d   = '0;
      set_pend = 1'b1;
    end else if (tick && (time_q != 16'h9959)) begin
      time_d   = {m10, m1, s10, s1};
      set_pend = 1'b1;
    end
  end

  // Next-state: CLEAR sweep, 5-cell WRITE bursts, IDLE waiting on pending
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    clr_cnt_d = clr_cnt_q;
    snap_d    = snap_q;
    pending_d = pending_q | set_pend;
    wr_first  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 13'd1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = S_WRITE;
          idx_d   = 3'd0;
        end
      end
      S_WRITE: begin
        wr_first = (idx_q == 3'd0);
        if (idx_q == 3'd4) begin
          if (pending_q || set_pend) begin
            idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      S_IDLE: begin
        // The IDLE edge that sees pending already emits the first character,
        // so the burst starts without a dead cycle.
        if (pending_q) begin
          wr_first = 1'b1;
          state_d  = S_WRITE;
          idx_d    = 3'd1;
        end
      end
      default: state_d = S_CLEAR;
    endcase
    if (wr_first) begin
      snap_d    = time_q;
      pending_d = set_pend;
    end
  end

  // Output: write strobe, address and character for the current cell
  always_comb begin
    we_d   = 1'b0;
    busy_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      S_CLEAR: begin
        we_d   = 1'b1;
        busy_d = 1'b1;
        addr_d = clr_cnt_q;
        data_d = ASCII_SP;
      end
      S_WRITE, S_IDLE: begin
        if ((state_q == S_WRITE) || pending_q) begin
          we_d   = 1'b1;
          busy_d = 1'b1;
          addr_d = BASE + {10'd0, (state_q == S_WRITE) ? idx_q : 3'd0};
          // Character 0 is emitted on the snapshot edge, so it takes the live
          // value that is being captured; the rest come from the snapshot.
          case ((state_q == S_WRITE) ? idx_q : 3'd0)
            3'd0:    data_d = ASCII_0 + {3'd0, time_q[15:12]};
            3'd1:    data_d = ASCII_0 + {3'd0, snap_q[11:8]};
            3'd2:    data_d = ASCII_COL;
            3'd3:    data_d = ASCII_0 + {3'd0, snap_q[7:4]};
            default: data_d = ASCII_0 + {3'd0, snap_q[3:0]};
          endcase
        end
      end
      default: begin
        we_d   = 1'b0;
        busy_d = 1'b1;
      end
    endcase
  end

  assign charRamAddrA = addr_q;
  assign charRamDataA = data_q;
  assign charRamWeA   = we_q;
  assign busy         = busy_q;
  assign timeBcd      = time_q;

endmodule
